// File: rtl/cdc_pkg.sv
// Shared definitions for the delay-sample CDC transmit scheduler.
package cdc_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SEND = S_SEND,
    ST_GAP  = S_GAP
  } state_t;

endpackage

// File: rtl/cdc_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  int unsigned k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(ptr) + i) % N_REQ;
      if (!valid && req[IW'(k)]) begin
        valid          = 1'b1;
        idx            = IW'(k);
        gnt[IW'(k)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_tx_sched.sv
// Source-domain scheduler sharing one delay-sample channel between N_REQ requesters,
// holding din stable across the HOLD/GAP window so the destination always samples a settled word.
module cdc_tx_sched
  import cdc_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned HOLD_CYC = 1,
  parameter int unsigned GAP_CYC  = 1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IW      = $clog2(N_REQ)
) (
  input  logic                clka,
  input  logic                rst,
  input  logic                en,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       din,
  output logic                din_en,
  output logic [IW-1:0]       gnt_idx,
  output logic                busy,
  output logic [CNT_W-1:0]    xfer_cnt
);

  localparam int unsigned PW = 4;

  state_t             state_q, state_d;
  logic [PW-1:0]      ph_q, ph_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [N_REQ-1:0]   ack_d;
  logic [DW-1:0]      din_d;
  logic               din_en_d;
  logic [IW-1:0]      gnt_idx_d;
  logic               busy_d;
  logic [CNT_W-1:0]   cnt_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic [DW-1:0]      wrd [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_wrd
    assign wrd[g] = data[g*DW +: DW];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .ptr   (rr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // State register and registered outputs
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ph_q     <= '0;
      rr_q     <= '0;
      ack      <= '0;
      din      <= '0;
      din_en   <= 1'b0;
      gnt_idx  <= '0;
      busy     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      rr_q     <= rr_d;
      ack      <= ack_d;
      din      <= din_d;
      din_en   <= din_en_d;
      gnt_idx  <= gnt_idx_d;
      busy     <= busy_d;
      xfer_cnt <= cnt_d;
    end
  end

  // Next state; ph_q counts cycles already spent in the current SEND/GAP phase
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    rr_d      = rr_q;
    ack_d     = '0;
    din_d     = din;
    din_en_d  = 1'b0;
    gnt_idx_d = gnt_idx;
    busy_d    = 1'b0;
    cnt_d     = xfer_cnt;
    unique case (state_q)
      ST_IDLE: begin
        if (en && arb_valid) begin
          state_d   = ST_SEND;
          ph_d      = '0;
          din_d     = wrd[arb_idx];
          din_en_d  = 1'b1;
          busy_d    = 1'b1;
          ack_d     = arb_gnt;
          gnt_idx_d = arb_idx;
          rr_d      = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_SEND: begin
        busy_d = 1'b1;
        if (ph_q == PW'(HOLD_CYC - 1)) begin
          state_d = ST_GAP;
          ph_d    = '0;
          if (xfer_cnt != '1) cnt_d = xfer_cnt + 1'b1;
        end else begin
          ph_d     = ph_q + 1'b1;
          din_en_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (ph_q == PW'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
          ph_d    = '0;
        end else begin
          ph_d   = ph_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_tx_sched.sv
// Directed bench for cdc_tx_sched: default instance plus a HOLD=3/GAP=2/CNT_W=2 instance.
module tb_cdc_tx_sched;

  logic clk;
  int   n_cmp;
  int   n_bad;

  logic         rst_d, en_d;
  logic [3:0]   req_d;
  logic [127:0] data_d;
  logic [3:0]   ack_d;
  logic [31:0]  din_d;
  logic         din_en_d;
  logic [1:0]   gnt_d;
  logic         busy_d;
  logic [15:0]  cnt_d;

  logic         rst_s, en_s;
  logic [3:0]   req_s;
  logic [127:0] data_s;
  logic [3:0]   ack_s;
  logic [31:0]  din_s;
  logic         din_en_s;
  logic [1:0]   gnt_s;
  logic         busy_s;
  logic [1:0]   cnt_s;

  cdc_tx_sched u_def (
    .clka(clk), .rst(rst_d), .en(en_d), .req(req_d), .data(data_d),
    .ack(ack_d), .din(din_d), .din_en(din_en_d), .gnt_idx(gnt_d),
    .busy(busy_d), .xfer_cnt(cnt_d)
  );

  cdc_tx_sched #(.HOLD_CYC(3), .GAP_CYC(2), .CNT_W(2)) u_spc (
    .clka(clk), .rst(rst_s), .en(en_s), .req(req_s), .data(data_s),
    .ack(ack_s), .din(din_s), .din_en(din_en_s), .gnt_idx(gnt_s),
    .busy(busy_s), .xfer_cnt(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] words [4];
    int          exp_idx [4];
    int          acks;
    n_cmp = 0;
    n_bad = 0;
    words[0] = 32'h5566740d;
    words[1] = 32'h5566b72e;
    words[2] = 32'h12345678;
    words[3] = 32'h55663d70;
    exp_idx  = '{0, 1, 3, 0};

    rst_d = 1'b1; en_d = 1'b1; req_d = 4'b1111; data_d = {4{32'hdeadbeef}};
    rst_s = 1'b1; en_s = 1'b1; req_s = 4'b0000; data_s = '0;

    // reset held with all requests pending
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ack", 64'(ack_d), 64'h0);
      chk("rst_din_en", 64'(din_en_d), 64'h0);
      chk("rst_din", 64'(din_d), 64'h0);
      chk("rst_cnt", 64'(cnt_d), 64'h0);
    end
    chk("rst_gnt", 64'(gnt_d), 64'h0);
    chk("rst_busy", 64'(busy_d), 64'h0);

    // single requester
    rst_d = 1'b0; req_d = 4'b0100; data_d = '0; data_d[2*32 +: 32] = 32'h55667788;
    tick();
    chk("s_ack", 64'(ack_d), 64'h4);
    chk("s_din", 64'(din_d), 64'h55667788);
    chk("s_din_en", 64'(din_en_d), 64'h1);
    chk("s_gnt", 64'(gnt_d), 64'h2);
    chk("s_busy", 64'(busy_d), 64'h1);
    req_d = 4'b0000;
    tick();
    chk("s_ack_pulse", 64'(ack_d), 64'h0);
    chk("s_gap_en", 64'(din_en_d), 64'h0);
    chk("s_gap_din", 64'(din_d), 64'h55667788);
    chk("s_cnt", 64'(cnt_d), 64'h1);
    chk("s_gap_busy", 64'(busy_d), 64'h1);
    tick();
    chk("s_idle_busy", 64'(busy_d), 64'h0);
    chk("s_idle_din", 64'(din_d), 64'h55667788);

    // contention from a fresh rr pointer
    rst_d = 1'b1;
    tick();
    rst_d = 1'b0;
    for (int k = 0; k < 4; k++) data_d[k*32 +: 32] = words[k];
    req_d = 4'b1011;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (t % 3 == 0) begin
        chk("c_ack", 64'(ack_d), 64'(4'b0001 << exp_idx[t/3]));
        chk("c_gnt", 64'(gnt_d), 64'(exp_idx[t/3]));
        chk("c_din", 64'(din_d), 64'(words[exp_idx[t/3]]));
        chk("c_din_en", 64'(din_en_d), 64'h1);
      end else begin
        chk("c_ack_idle", 64'(ack_d), 64'h0);
      end
    end
    chk("c_cnt", 64'(cnt_d), 64'h3);
    req_d = 4'b0000;
    tick();
    tick();

    // en gating
    en_d = 1'b0; req_d = 4'b0001;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("en_ack", 64'(ack_d), 64'h0);
      chk("en_din_en", 64'(din_en_d), 64'h0);
    end
    chk("en_cnt", 64'(cnt_d), 64'h4);

    // reset in the second SEND cycle of a HOLD=3 transfer
    data_s = '0;
    data_s[1*32 +: 32] = 32'haaaa0001;
    data_s[2*32 +: 32] = 32'hbbbb0002;
    rst_s = 1'b0; req_s = 4'b0010;
    tick();
    chk("m_ack", 64'(ack_s), 64'h2);
    chk("m_din_en1", 64'(din_en_s), 64'h1);
    tick();
    chk("m_din_en2", 64'(din_en_s), 64'h1);
    rst_s = 1'b1;
    tick();
    chk("m_rst_en", 64'(din_en_s), 64'h0);
    chk("m_rst_busy", 64'(busy_s), 64'h0);
    chk("m_rst_cnt", 64'(cnt_s), 64'h0);
    chk("m_rst_ack", 64'(ack_s), 64'h0);
    rst_s = 1'b0; req_s = 4'b0110;

    // regrant from pointer 0, then back-to-back spacing check
    tick();
    chk("p_ack", 64'(ack_s), 64'h2);
    chk("p_gnt", 64'(gnt_s), 64'h1);
    req_s = 4'b0100;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) tick();
      chk("p_din_stable", 64'(din_s), 64'haaaa0001);
      chk("p_din_en", 64'(din_en_s), (t < 3) ? 64'h1 : 64'h0);
      if (t > 0) chk("p_ack_quiet", 64'(ack_s), 64'h0);
    end
    chk("p_cnt1", 64'(cnt_s), 64'h1);
    tick();
    chk("p2_ack", 64'(ack_s), 64'h4);
    chk("p2_gnt", 64'(gnt_s), 64'h2);
    chk("p2_din", 64'(din_s), 64'hbbbb0002);
    chk("p2_din_en", 64'(din_en_s), 64'h1);
    req_s = 4'b0000;
    for (int t = 0; t < 6; t++) tick();
    chk("p2_cnt", 64'(cnt_s), 64'h2);
    chk("p2_busy", 64'(busy_s), 64'h0);

    // saturation: three more transfers on a 2-bit counter
    req_s = 4'b0001;
    acks = 0;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (ack_s == 4'b0001) acks++;
      if (t == 13) req_s = 4'b0000;
      if (t == 10) chk("sat_mid", 64'(cnt_s), 64'h3);
    end
    tick();
    chk("sat_acks", 64'(acks), 64'h3);
    chk("sat_cnt", 64'(cnt_s), 64'h3);
    chk("sat_busy", 64'(busy_s), 64'h0);
    chk("sat_din_en", 64'(din_en_s), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
